// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access unit:
// access-size encodings, FSM states, the latched request and strobe/lane helpers.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MASK_BYTE = 2'b00,
        MASK_HALF = 2'b01,
        MASK_WORD = 2'b10,
        MASK_ILL  = 2'b11
    } mask_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    typedef struct packed {
        logic        we;
        mask_e       mask;
        logic        sext;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    // Both-ops, reserved size and natural-alignment violations all count as illegal.
    function automatic logic is_illegal(input logic rd, input logic wr,
                                        input logic [1:0] mask, input logic [1:0] off);
        logic bad;
        case (mask_e'(mask))
            MASK_BYTE: bad = 1'b0;
            MASK_HALF: bad = off[0];
            MASK_WORD: bad = |off;
            default:   bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

    function automatic logic [3:0] make_wstrb(input logic [1:0] mask, input logic [1:0] off);
        logic [3:0] strb;
        case (mask_e'(mask))
            MASK_BYTE: strb = 4'b0001 << off;
            MASK_HALF: strb = 4'b0011 << off;
            default:   strb = 4'hF;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] mask, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (mask_e'(mask))
            MASK_BYTE: lanes = {4{wdata[7:0]}};
            MASK_HALF: lanes = {2{wdata[15:0]}};
            default:   lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational load aligner: shifts the read word down by the byte offset,
// then masks and sign/zero-extends to the access size. Also usable on a WB forwarding path.
module mem_access_unit_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mask_e       mask,
    input  logic        sext,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (mask)
            MASK_BYTE: load_data = {{24{sext & shifted[7]}}, shifted[7:0]};
            MASK_HALF: load_data = {{16{sext & shifted[15]}}, shifted[15:0]};
            default:   load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: valid/ready bus master with stall,
// byte strobes, store-lane replication, load alignment, timeout and flush handling.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_memRead,
    input  logic        mem_memWrite,
    input  logic [1:0]  mem_maskMode,
    input  logic        mem_sext,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        flush,
    output logic        dmem_valid,
    input  logic        dmem_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    req_t               req_q, req_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               discard_q, discard_d;
    logic               err_q, err_d;
    logic               misalign_q, misalign_d;
    logic [31:0]        load_data_q, load_data_d;

    logic               illegal;
    logic               start;
    logic               timed_out;
    logic [31:0]        aligned;

    mem_access_unit_align u_align (
        .rdata     (dmem_rdata),
        .offset    (req_q.addr[1:0]),
        .mask      (req_q.mask),
        .sext      (req_q.sext),
        .load_data (aligned)
    );

    // Start is gated by reset so stall cannot leak out while reset is held.
    assign illegal   = is_illegal(mem_memRead, mem_memWrite, mem_maskMode, mem_addr[1:0]);
    assign start     = reset & (mem_memRead ^ mem_memWrite) & ~illegal & ~flush;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        err_d       = err_q;
        load_data_d = load_data_q;
        misalign_d  = 1'b0;
        stall       = 1'b0;
        load_valid  = 1'b0;
        bus_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                misalign_d = reset & (mem_memRead | mem_memWrite) & illegal & ~flush;
                if (start) begin
                    stall       = 1'b1;
                    state_d     = ST_REQ;
                    cnt_d       = '0;
                    discard_d   = 1'b0;
                    err_d       = 1'b0;
                    req_d.we    = mem_memWrite;
                    req_d.mask  = mask_e'(mem_maskMode);
                    req_d.sext  = mem_sext;
                    req_d.addr  = mem_addr;
                    req_d.wstrb = mem_memWrite ? make_wstrb(mem_maskMode, mem_addr[1:0]) : 4'h0;
                    req_d.wdata = replicate(mem_maskMode, mem_wdata);
                end
            end
            ST_REQ: begin
                stall     = 1'b1;
                discard_d = discard_q | flush;
                if (dmem_ready) begin
                    state_d = req_q.we ? ST_DONE : ST_RESP;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    bus_err = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                    if (!req_q.we) load_data_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                stall     = 1'b1;
                discard_d = discard_q | flush;
                if (dmem_rvalid) begin
                    state_d = ST_DONE;
                    if (!discard_d) load_data_d = aligned;
                end else if (timed_out) begin
                    bus_err     = 1'b1;
                    err_d       = 1'b1;
                    state_d     = ST_DONE;
                    load_data_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                load_valid = ~req_q.we & ~discard_q & ~err_q;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        dmem_valid = (state_q == ST_REQ);
        dmem_we    = dmem_valid & req_q.we;
        dmem_addr  = dmem_valid ? {req_q.addr[31:2], 2'b00} : 32'h0;
        dmem_wstrb = dmem_valid ? req_q.wstrb : 4'h0;
        dmem_wdata = dmem_valid ? req_q.wdata : 32'h0;
        load_data  = load_data_q;
        misalign   = misalign_q;
    end

    // NOTE: the request latch is reset along with control so the bus never sees stale values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            err_q       <= 1'b0;
            misalign_q  <= 1'b0;
            load_data_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            err_q       <= err_d;
            misalign_q  <= misalign_d;
            load_data_q <= load_data_d;
        end
    end

endmodule
